// File: rtl/irq_pkg.sv
// Shared definitions for the machine-level interrupt controller.
// Register offsets, cause codes, enable bit indices and FSM encoding.
package irq_pkg;

  localparam logic [4:0] OFF_MSIP    = 5'h00;
  localparam logic [4:0] OFF_CMP_LO  = 5'h04;
  localparam logic [4:0] OFF_CMP_HI  = 5'h08;
  localparam logic [4:0] OFF_TIME_LO = 5'h0C;
  localparam logic [4:0] OFF_TIME_HI = 5'h10;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  localparam int MIE_MSI = 3;
  localparam int MIE_MTI = 7;
  localparam int MIE_MEI = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_pend_t;

  function automatic logic [31:0] sel_cause(
    input irq_pend_t p
  );
    logic [31:0] c;
    c = CAUSE_MTI;
    if (p.mei)      c = CAUSE_MEI;
    else if (p.msi) c = CAUSE_MSI;
    return c;
  endfunction

endpackage

// File: rtl/irq_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 on synchronous reset.
module irq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: MSIP, optional mtime/mtimecmp, MEIP sync.
// Timer storage exists only when IRQ_CTRL_MTIME_EN is defined.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq_in,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic        irq_ack,
  output logic        irq_req,
  output logic [31:0] irq_cause
);

  logic        meip;
  logic        mtip;
  logic        msip;
  logic [31:0] rd_val;
  irq_pend_t   pend;
  logic        any_pend;
  irq_state_e  state_q;
  irq_state_e  state_d;
  logic        unused_ok;

  assign unused_ok = ^{mie[31:12], mie[10:8], mie[6:4],
                       mie[2:0], bus_wdata[31:1]};

  irq_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq_in),
    .q   (meip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      msip <= 1'b0;
    end else if (bus_we && bus_addr == OFF_MSIP) begin
      msip <= bus_wdata[0];
    end
  end

`ifdef IRQ_CTRL_MTIME_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  // A write to either half of mtime suppresses that cycle's tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (bus_we && bus_addr == OFF_TIME_LO) begin
        mtime[31:0] <= bus_wdata;
      end else if (bus_we && bus_addr == OFF_TIME_HI) begin
        mtime[63:32] <= bus_wdata;
      end else begin
        mtime <= mtime + 64'd1;
      end
      if (bus_we && bus_addr == OFF_CMP_LO) begin
        mtimecmp[31:0] <= bus_wdata;
      end
      if (bus_we && bus_addr == OFF_CMP_HI) begin
        mtimecmp[63:32] <= bus_wdata;
      end
    end
  end

  assign mtip = (mtime >= mtimecmp);

  always_comb begin
    rd_val = '0;
    unique case (bus_addr)
      OFF_MSIP:    rd_val = {31'd0, msip};
      OFF_CMP_LO:  rd_val = mtimecmp[31:0];
      OFF_CMP_HI:  rd_val = mtimecmp[63:32];
      OFF_TIME_LO: rd_val = mtime[31:0];
      OFF_TIME_HI: rd_val = mtime[63:32];
      default:     rd_val = '0;
    endcase
  end
`else
  assign mtip = 1'b0;

  always_comb begin
    rd_val = '0;
    if (bus_addr == OFF_MSIP) begin
      rd_val = {31'd0, msip};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      bus_rdata <= rd_val;
    end
  end

  assign pend.mei = meip & mie[MIE_MEI] & mstatus_mie;
  assign pend.msi = msip & mie[MIE_MSI] & mstatus_mie;
  assign pend.mti = mtip & mie[MIE_MTI] & mstatus_mie;
  assign any_pend = |pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack beats withdrawal so the exception unit always sees HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_pend) state_d = ST_REQ;
      ST_REQ: begin
        if (irq_ack)        state_d = ST_HOLD;
        else if (!any_pend) state_d = ST_IDLE;
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_req = (state_q == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_cause <= '0;
    end else if (state_q == ST_IDLE && any_pend) begin
      irq_cause <= sel_cause(pend);
    end
  end

endmodule
